binary_to_decimal: RTL and testbench
====================================

# binary_to_decimal

Registered 4-bit binary to two-digit BCD converter. Splits an unsigned value 0–15 into a tens flag `z` (tens digit 0 or 1) and a ones digit `m` (0–9). It sits between the calculator's 4-bit result path and the decimal display driver. Results appear one clock after the input is sampled.

## Interface
Parameters:
- none.

Ports:
- `clk`  input  1  single system clock; all state updates on the rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `in_valid`  input  1  qualifies `v`; sampled on each rising edge.
- `v`  input  4  unsigned binary operand, 0–15.
- `out_valid`  output  1  high for one cycle per accepted input; registered.
- `z`  output  1  tens digit: 1 when the converted value is 10–15, else 0; registered.
- `m`  output  4  BCD ones digit, 0–9; registered.
- `seg_tens`  output  7  present only with `BIN2DEC_SEG_EN`; active-low segments {g,f,e,d,c,b,a} for the tens digit; registered.
- `seg_ones`  output  7  present only with `BIN2DEC_SEG_EN`; active-low segments {g,f,e,d,c,b,a} for the ones digit; registered.

## Operation
- Comparator: `z_next = (v > 9)`. This is true exactly for v ∈ {10..15}; it is implemented as v[3] & (v[2] | v[1]).
- Ones digit: `m_next = z_next ? (v − 10) : v`, taken mod 16 and truncated to 4 bits.
  - For v 10–15, m is 0–5.
  - For v 0–9, m equals v.
  - m is never 10–15.
- Capture: on a rising edge with `in_valid` = 1, `z`/`m` load `z_next`/`m_next` and `out_valid` is set to 1.
- Hold: on a rising edge with `in_valid` = 0, `z`/`m` hold their previous values and `out_valid` is set to 0.
- Back-to-back operation: consecutive valid inputs produce consecutive valid outputs with no bubbles. Throughput is one conversion per clock.
- No backpressure: the downstream block must accept every `out_valid` pulse.
- Decimal value represented by the outputs is always 10·z + m, which equals the v that was captured.

## Timing
- Reset: with `rst` = 1 at a rising edge, `z`=0, `m`=0, `out_valid`=0, and (with the macro) `seg_tens`/`seg_ones` = 7'b1000000 (shows "0").
- Reset priority: `rst` overrides `in_valid`. An input presented in the same cycle as reset is dropped.
- Latency: exactly 1 cycle from the sampling edge to the outputs.
- Output glitching: outputs are all driven from flops, so there is no combinational path from input to output.
- Reset mid-stream: a value captured on edge N is cleared if `rst` is high on edge N+1. No stale value reappears after reset.
- Input changes between edges have no effect on the outputs.

## Configuration
- Macro: `BIN2DEC_SEG_EN`.
  - Defined: adds the `seg_tens` and `seg_ones` ports, driven by a registered seven-segment decode of `z` and `m`. They are updated on the same edge and with the same 1-cycle latency as `m`.
    - Active-low patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
    - When `z`=0, the tens digit shows the "0" pattern, not blank.
  - Undefined: the ports, the decode logic and the segment flops are absent. `z`/`m`/`out_valid` behaviour is identical in both builds.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `in_valid`=1, v=13 -> z=0, m=0, out_valid=0 throughout. With the macro, both seg outputs = 1000000.
- Exhaustive sweep: `in_valid`=1, v=0..15 on consecutive cycles. Each output appears one cycle later as (z,m): 0–9 -> (0,v), 10->(1,0), 11->(1,1), 12->(1,2), 13->(1,3), 14->(1,4), 15->(1,5). `out_valid` stays continuously 1.
- Hold: v=12 valid, then `in_valid`=0 with v=3 -> z=1, m=2 held, `out_valid` pulses for 1 cycle only.
- Boundary: v=9 then v=10 -> (0,9) then (1,0), with no intermediate value.
- Reset mid-stream: v=15 valid on edge N, `rst`=1 on edge N+1 -> z=0, m=0, out_valid=0 after edge N+1.
- Segment build: v=14 with the macro defined -> seg_tens=1111001, seg_ones=0011001 one cycle later.

Source files
------------

// File: rtl/binary_to_decimal.sv
`default_nettype none
// ============================================================================
// Module      : binary_to_decimal
// Description : Registered 4-bit binary to two-digit BCD converter. Splits an
//               unsigned value 0-15 into a tens flag (z, 0 or 1) and a ones
//               digit (m, 0-9). Outputs follow the sampling edge by one clock.
//
//               Ports:
//                 clk       - system clock, rising-edge active
//                 rst       - synchronous active-high reset
//                 in_valid  - qualifies v on each rising edge
//                 v[3:0]    - unsigned binary operand, 0-15
//                 out_valid - one-cycle pulse per accepted input
//                 z         - tens digit (1 for 10-15)
//                 m[3:0]    - BCD ones digit
//                 seg_tens  - (BIN2DEC_SEG_EN only) active-low {g..a}, tens
//                 seg_ones  - (BIN2DEC_SEG_EN only) active-low {g..a}, ones
//
//               Optional feature macro: BIN2DEC_SEG_EN adds the registered
//               seven-segment outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module binary_to_decimal (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       in_valid,
    input  wire logic [3:0] v,
    output logic            out_valid,
    output logic            z,
    output logic [3:0]      m
`ifdef BIN2DEC_SEG_EN
    ,
    output logic [6:0]      seg_tens,
    output logic [6:0]      seg_ones
`endif
);

    // Active-low "0" glyph, also the reset pattern of both displays.
    localparam logic [6:0] c_SEG_ZERO = 7'b1000000;
    localparam logic [6:0] c_SEG_ONE  = 7'b1111001;
    localparam logic [3:0] c_TEN      = 4'd10;

    logic       w_z_next;
    logic [3:0] w_m_next;

    logic       r_out_valid;
    logic       r_z;
    logic [3:0] r_m;

    // v > 9 reduces to bit 3 set together with bit 2 or bit 1.
    assign w_z_next = v[3] & (v[2] | v[1]);
    // Subtraction wraps mod 16; only used when v >= 10 so result is 0-5.
    assign w_m_next = w_z_next ? (v - c_TEN) : v;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_z         <= 1'b0;
            r_m         <= 4'd0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_z <= w_z_next;
                r_m <= w_m_next;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign z         = r_z;
    assign m         = r_m;

`ifdef BIN2DEC_SEG_EN
    logic [6:0] r_seg_tens;
    logic [6:0] r_seg_ones;

    function automatic logic [6:0] f_seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // Decode the next-state digits so the segments land on the same edge as m.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg_tens <= c_SEG_ZERO;
            r_seg_ones <= c_SEG_ZERO;
        end else if (in_valid) begin
            r_seg_tens <= w_z_next ? c_SEG_ONE : c_SEG_ZERO;
            r_seg_ones <= f_seg_decode(w_m_next);
        end
    end

    assign seg_tens = r_seg_tens;
    assign seg_ones = r_seg_ones;
`endif

endmodule
`default_nettype wire

// File: tb/tb_binary_to_decimal.sv
`default_nettype none
// ============================================================================
// Module      : tb_binary_to_decimal
// Description : Scoreboard bench for binary_to_decimal. The driver pushes the
//               hand-computed {z,m} for each accepted input; an independent
//               monitor checks every cycle on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_binary_to_decimal;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] v;
    logic       out_valid;
    logic       z;
    logic [3:0] m;
`ifdef BIN2DEC_SEG_EN
    logic [6:0] seg_tens;
    logic [6:0] seg_ones;
`endif

    binary_to_decimal u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .v         (v),
        .out_valid (out_valid),
        .z         (z),
        .m         (m)
`ifdef BIN2DEC_SEG_EN
        ,
        .seg_tens  (seg_tens),
        .seg_ones  (seg_ones)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {z, m[3:0]} per accepted input.
    logic [4:0] exp_q[$];
    logic [4:0] hold_exp;
    int         checks;
    int         errors;
    bit         mon_en;

    // Hand-computed sweep results, packed as {z, m}.
    logic [4:0] sweep_exp [16] = '{
        5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07,
        5'h08, 5'h09, 5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15
    };

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

`ifdef BIN2DEC_SEG_EN
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction
`endif

    // Drive one cycle of stimulus just after the falling edge; the monitor has
    // already sampled that edge, so queue updates here refer to the next edge.
    task automatic drive(input logic r, input logic vld, input logic [3:0] val,
                         input logic [4:0] exp);
        @(negedge clk);
        #2;
        rst      = r;
        in_valid = vld;
        v        = val;
        if (r) begin
            exp_q.delete();
            hold_exp = 5'h00;
        end else if (vld) begin
            exp_q.push_back(exp);
        end
    endtask

    // Monitor: out_valid must match scoreboard occupancy; z/m must always
    // show the last popped (or reset) value.
    initial begin
        logic [4:0] e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("out_valid", int'(out_valid), int'(exp_q.size() > 0));
                if (out_valid && exp_q.size() > 0) begin
                    e        = exp_q.pop_front();
                    hold_exp = e;
                end
                check("z", int'(z), int'(hold_exp[4]));
                check("m", int'(m), int'(hold_exp[3:0]));
`ifdef BIN2DEC_SEG_EN
                check("seg_tens", int'(seg_tens),
                      int'(hold_exp[4] ? 7'b1111001 : 7'b1000000));
                check("seg_ones", int'(seg_ones), int'(seg_of(hold_exp[3:0])));
`endif
            end
        end
    end

    initial begin
        checks   = 0;
        errors   = 0;
        hold_exp = 5'h00;
        rst      = 1'b1;
        in_valid = 1'b1;
        v        = 4'd13;
        mon_en   = 1'b1;

        // Two reset edges with a valid input present: input must be dropped.
        drive(1'b1, 1'b1, 4'd13, 5'h00);

        // Back-to-back sweep of every input value.
        for (int i = 0; i < 16; i++)
            drive(1'b0, 1'b1, 4'(i), sweep_exp[i]);

        // Hold: 12 then an unqualified 3 must leave (1,2) displayed.
        drive(1'b0, 1'b1, 4'd12, 5'h12);
        drive(1'b0, 1'b0, 4'd3,  5'h00);
        drive(1'b0, 1'b0, 4'd7,  5'h00);

        // Boundary 9 -> 10.
        drive(1'b0, 1'b1, 4'd9,  5'h09);
        drive(1'b0, 1'b1, 4'd10, 5'h10);
        drive(1'b0, 1'b0, 4'd0,  5'h00);

        // Reset mid-stream: 15 captured, then cleared on the next edge.
        drive(1'b0, 1'b1, 4'd15, 5'h15);
        drive(1'b1, 1'b0, 4'd0,  5'h00);
        drive(1'b0, 1'b0, 4'd0,  5'h00);
        drive(1'b0, 1'b0, 4'd0,  5'h00);

        // 14 -> (1,4); segment build shows 1111001 / 0011001.
        drive(1'b0, 1'b1, 4'd14, 5'h14);
        drive(1'b0, 1'b0, 4'd5,  5'h00);
        drive(1'b0, 1'b0, 4'd5,  5'h00);

        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
